// File: rtl/secuenciador_suma_nibbles.sv
`default_nettype none
// ============================================================================
// Module   : secuenciador_suma_nibbles
// Summary  : Wide adder built from one shared external 4-bit adder, one nibble per clock, LS first.
// Revision : 1.0 - initial release
// ============================================================================
module secuenciador_suma_nibbles #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inicio,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 ocupado,
  output logic                 listo,
  output logic [4*NIBBLES-1:0] suma,
  output logic                 cout,
  output logic [3:0]           sa_a,
  output logic [3:0]           sa_b,
  output logic                 sa_cin,
  input  logic [3:0]           sa_s,
  input  logic                 sa_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] REPOSO  = 2'd0;
  localparam logic [1:0] SUMANDO = 2'd1;
  localparam logic [1:0] FIN     = 2'd2;

  localparam logic [CW-1:0] c_last = CW'(NIBBLES - 1);

  logic [1:0]    r_state;
  logic [W-1:0]  r_op_a;
  logic [W-1:0]  r_op_b;
  logic [W-1:0]  r_res;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  w_res_next;
  logic          w_sumando;

  // Each adder nibble enters at the top; after NIBBLES shifts the result is aligned.
  generate
    if (NIBBLES == 1) begin : g_one_nibble
      assign w_res_next = sa_s;
    end else begin : g_multi_nibble
      assign w_res_next = {sa_s, r_res[W-1:4]};
    end
  endgenerate

  assign w_sumando = (r_state == SUMANDO);
  assign ocupado   = w_sumando;
  assign listo     = (r_state == FIN);
  assign sa_a      = w_sumando ? r_op_a[3:0] : 4'd0;
  assign sa_b      = w_sumando ? r_op_b[3:0] : 4'd0;
  assign sa_cin    = w_sumando ? r_carry : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= REPOSO;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      suma    <= '0;
      cout    <= 1'b0;
    end else begin
      case (r_state)
        SUMANDO: begin
          r_op_a  <= r_op_a >> 4;
          r_op_b  <= r_op_b >> 4;
          r_res   <= w_res_next;
          r_carry <= sa_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            suma    <= w_res_next;
            cout    <= sa_cout;
            r_state <= FIN;
          end
        end
        REPOSO, FIN: begin
          // FIN accepts a new start so operations can run back to back.
          if (inicio) begin
            r_op_a  <= a;
            r_op_b  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_res   <= '0;
            r_state <= SUMANDO;
          end else begin
            r_state <= REPOSO;
          end
        end
        default: r_state <= REPOSO;
      endcase
    end
  end

endmodule
`default_nettype wire
